// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor
// Sequences the rPLL RESET / LOCK handshake in the clkin domain and produces
// the downstream system reset. LOCK is synchronised, qualified for a stable
// interval, and then sys_rst_n is released. Lock timeouts trigger retries.
// A failure is latched after the retries are exhausted. Loss of lock while
// running re-sequences the PLL.
//
// Optional feature macro: PLL_LOL_COUNT_EN
//   When defined, adds lol_count[7:0]. This is a saturating count of
//   RUN->RESET_PLL exits caused by loss of lock. Only reset_n clears it.
module pll_lock_supervisor #(
    parameter int RST_PULSE_CYCLES = 16,
    parameter int LOCK_TIMEOUT     = 14000,
    parameter int STABLE_CYCLES    = 1024,
    parameter int MAX_RETRIES      = 3,
    localparam int RETRY_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1
) (
    input  logic               clkin,
    input  logic               reset_n,
    input  logic               pll_lock,
    input  logic               relock_req,
    output logic               pll_reset,
    output logic               sys_rst_n,
    output logic               ready,
    output logic               fail,
    output logic [RETRY_W-1:0] retry_cnt,
    output logic [2:0]         state
`ifdef PLL_LOL_COUNT_EN
    ,
    output logic [7:0]         lol_count
`endif
);

    localparam int CNT_MAX_A = (RST_PULSE_CYCLES > LOCK_TIMEOUT) ? RST_PULSE_CYCLES : LOCK_TIMEOUT;
    localparam int CNT_MAX   = (CNT_MAX_A > STABLE_CYCLES) ? CNT_MAX_A : STABLE_CYCLES;
    localparam int CNT_W     = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0]   CNT_ZERO     = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]   CNT_ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0]   RST_LAST     = CNT_W'(RST_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_ZERO   = {RETRY_W{1'b0}};
    localparam logic [RETRY_W-1:0] RETRY_ONE    = RETRY_W'(1);
    localparam logic [RETRY_W-1:0] RETRY_LAST   = RETRY_W'(MAX_RETRIES);

    typedef enum logic [2:0] {
        RESET_PLL = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        FAIL      = 3'd4
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [RETRY_W-1:0] retry_q, retry_d;

    logic lock_meta_q;
    logic lock_s_q;

    logic pll_reset_q, pll_reset_d;
    logic sys_rst_n_q, sys_rst_n_d;
    logic ready_q, ready_d;
    logic fail_q, fail_d;

    // Two-flop synchroniser bringing the asynchronous PLL LOCK into clkin
    always_ff @(posedge clkin or negedge reset_n) begin
        if (!reset_n) begin
            lock_meta_q <= 1'b0;
            lock_s_q    <= 1'b0;
        end else begin
            lock_meta_q <= pll_lock;
            lock_s_q    <= lock_meta_q;
        end
    end

    // State register with the shared dwell counter and the attempt counter
    always_ff @(posedge clkin or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= RESET_PLL;
            cnt_q   <= CNT_ZERO;
            retry_q <= RETRY_ZERO;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            retry_q <= retry_d;
        end
    end

    // Next-state logic; relock_req overrides every state and every event
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_ONE;
        retry_d = retry_q;
        if (relock_req) begin
            state_d = RESET_PLL;
            cnt_d   = CNT_ZERO;
            retry_d = RETRY_ZERO;
        end else begin
            case (state_q)
                RESET_PLL: begin
                    if (cnt_q == RST_LAST) begin
                        state_d = WAIT_LOCK;
                        cnt_d   = CNT_ZERO;
                    end else begin
                        state_d = RESET_PLL;
                    end
                end
                WAIT_LOCK: begin
                    if (lock_s_q) begin
                        state_d = STABLE;
                        cnt_d   = CNT_ZERO;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        cnt_d = CNT_ZERO;
                        if (retry_q == RETRY_LAST) begin
                            state_d = FAIL;
                        end else begin
                            state_d = RESET_PLL;
                            retry_d = retry_q + RETRY_ONE;
                        end
                    end else begin
                        state_d = WAIT_LOCK;
                    end
                end
                STABLE: begin
                    if (!lock_s_q) begin
                        // A glitch restarts the lock timeout but costs no retry
                        state_d = WAIT_LOCK;
                        cnt_d   = CNT_ZERO;
                    end else if (cnt_q == STABLE_LAST) begin
                        state_d = RUN;
                        cnt_d   = CNT_ZERO;
                    end else begin
                        state_d = STABLE;
                    end
                end
                RUN: begin
                    // Counter parks at zero so it can never wrap while idle
                    cnt_d = CNT_ZERO;
                    if (!lock_s_q) begin
                        state_d = RESET_PLL;
                        retry_d = RETRY_ZERO;
                    end else begin
                        state_d = RUN;
                    end
                end
                FAIL: begin
                    cnt_d   = CNT_ZERO;
                    state_d = FAIL;
                end
                default: begin
                    state_d = RESET_PLL;
                    cnt_d   = CNT_ZERO;
                    retry_d = RETRY_ZERO;
                end
            endcase
        end
    end

    // Output decode from the next state so the outputs line up with state_q
    always_comb begin
        pll_reset_d = 1'b0;
        sys_rst_n_d = 1'b0;
        ready_d     = 1'b0;
        fail_d      = 1'b0;
        case (state_d)
            RESET_PLL: begin
                pll_reset_d = 1'b1;
            end
            RUN: begin
                sys_rst_n_d = 1'b1;
                ready_d     = 1'b1;
            end
            FAIL: begin
                pll_reset_d = 1'b1;
                fail_d      = 1'b1;
            end
            default: begin
                pll_reset_d = 1'b0;
            end
        endcase
    end

    // Registered outputs so that downstream resets are glitch free
    always_ff @(posedge clkin or negedge reset_n) begin
        if (!reset_n) begin
            pll_reset_q <= 1'b1;
            sys_rst_n_q <= 1'b0;
            ready_q     <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            pll_reset_q <= pll_reset_d;
            sys_rst_n_q <= sys_rst_n_d;
            ready_q     <= ready_d;
            fail_q      <= fail_d;
        end
    end

`ifdef PLL_LOL_COUNT_EN
    logic [7:0] lol_q;
    logic       lol_inc_s;

    // Loss-of-lock exit from RUN; a relock_req exit in the same cycle does not count
    always_comb begin
        if ((state_q == RUN) && !lock_s_q && !relock_req) begin
            lol_inc_s = 1'b1;
        end else begin
            lol_inc_s = 1'b0;
        end
    end

    // Saturating loss-of-lock event counter, cleared only by reset_n
    always_ff @(posedge clkin or negedge reset_n) begin
        if (!reset_n) begin
            lol_q <= 8'd0;
        end else if (lol_inc_s && (lol_q != 8'hFF)) begin
            lol_q <= lol_q + 8'd1;
        end else begin
            lol_q <= lol_q;
        end
    end

    assign lol_count = lol_q;
`endif

    assign pll_reset = pll_reset_q;
    assign sys_rst_n = sys_rst_n_q;
    assign ready     = ready_q;
    assign fail      = fail_q;
    assign retry_cnt = retry_q;
    assign state     = state_q;

endmodule
